// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-fetch cache: address-split widths,
// controller state encoding and the NOP word returned when no fetch is served.
package icache_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic int ofs_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int line_bytes);
        return 32 - $clog2(lines) - $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: asynchronous read,
// one write port, and a global valid clear that wins over a same-edge write.
module icache_line_array #(
    parameter int LINES = 32,
    parameter int IDX_W = 5,
    parameter int TAG_W = 22,
    parameter int LW    = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [LW-1:0]    rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [LW-1:0]    wr_data,
    input  logic             clr
);

    logic             valid_reg [LINES];
    logic [TAG_W-1:0] tag_mem   [LINES];
    logic [LW-1:0]    data_mem  [LINES];

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (clr) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag and data need no reset: they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped read-only instruction cache front end: zero-latency hit path,
// single-line refill over a req/ack handshake, deferred flush, miss counter.
module icache_fetch_ctrl
    import icache_pkg::*;
#(
    parameter int LINES      = 32,
    parameter int LINE_BYTES = 32,
    parameter int CNT_W      = 16,
    localparam int LW        = 8 * LINE_BYTES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [31:0]      addr_i,
    input  logic             flush_i,
    output logic [31:0]      instr_o,
    output logic             stall_o,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    input  logic             mem_ack_i,
    input  logic [LW-1:0]    mem_data_i,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int OFS   = ofs_w(LINE_BYTES);
    localparam int IDX   = idx_w(LINES);
    localparam int TAG   = tag_w(LINES, LINE_BYTES);
    localparam int WORDS = LINE_BYTES / 4;

    state_t           state_reg;
    logic [31:0]      mem_addr_reg;
    logic [CNT_W-1:0] miss_cnt_reg;
    logic             flush_pend_reg;

    logic [IDX-1:0] idx;
    logic [TAG-1:0] tag;
    logic           rd_valid;
    logic [TAG-1:0] rd_tag;
    logic [LW-1:0]  rd_data;
    logic [31:0]    words [WORDS];
    logic [31:0]    word;
    logic           hit;
    logic           miss;
    logic           ack;
    logic           clr;
    logic           unused_bits;

    assign idx         = addr_i[OFS+IDX-1:OFS];
    assign tag         = addr_i[31:OFS+IDX];
    assign unused_bits = ^addr_i[1:0];

    assign hit  = (state_reg == IDLE) && req_i && rd_valid && (rd_tag == tag);
    assign miss = (state_reg == IDLE) && req_i && !hit;
    assign ack  = (state_reg == REQ) && mem_ack_i;

    // A flush seen during a refill is held back and lands on the ack edge,
    // so the freshly written line is invalidated together with the rest.
    assign clr = ((state_reg == IDLE) && flush_i) ||
                 (ack && (flush_i || flush_pend_reg));

    icache_line_array #(
        .LINES (LINES),
        .IDX_W (IDX),
        .TAG_W (TAG),
        .LW    (LW)
    ) u_lines (
        .clk      (clk_i),
        .rst      (rst_i),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (ack),
        .wr_idx   (mem_addr_reg[OFS+IDX-1:OFS]),
        .wr_tag   (mem_addr_reg[31:OFS+IDX]),
        .wr_data  (mem_data_i),
        .clr      (clr)
    );

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
            assign words[gi] = rd_data[gi*32 +: 32];
        end
        if (OFS > 2) begin : g_wsel
            assign word = words[addr_i[OFS-1:2]];
        end else begin : g_wone
            assign word = words[0];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            mem_addr_reg   <= 32'h0;
            miss_cnt_reg   <= '0;
            flush_pend_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss) begin
                        state_reg    <= REQ;
                        mem_addr_reg <= {addr_i[31:OFS], {OFS{1'b0}}};
                        if (miss_cnt_reg != '1) begin
                            miss_cnt_reg <= miss_cnt_reg + 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (ack) begin
                        state_reg      <= IDLE;
                        flush_pend_reg <= 1'b0;
                    end else if (flush_i) begin
                        flush_pend_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign instr_o    = hit ? word : NOP;
    assign stall_o    = (state_reg == REQ) || miss;
    assign mem_req_o  = (state_reg == REQ);
    assign mem_addr_o = mem_addr_reg;
    assign miss_cnt_o = miss_cnt_reg;

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed scenarios plus randomized traffic checked every cycle against an
// abstract cache model (arrays of lines, a pending-refill flag and a counter).
module tb_icache_fetch_ctrl;

    localparam int LINES = 32;
    localparam int LW    = 256;
    localparam int WORDS = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_i;
    logic [31:0]   addr_i;
    logic          flush_i;
    logic [31:0]   instr_o;
    logic          stall_o;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic          mem_ack_i;
    logic [LW-1:0] mem_data_i;
    logic [15:0]   miss_cnt_o;

    icache_fetch_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .flush_i    (flush_i),
        .instr_o    (instr_o),
        .stall_o    (stall_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .miss_cnt_o (miss_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Abstract model: what the cache holds, whether a refill is outstanding.
    bit            m_valid [LINES];
    logic [21:0]   m_tag   [LINES];
    logic [LW-1:0] m_data  [LINES];
    bit            m_busy;
    bit            m_flush_pend;
    logic [31:0]   m_addr;
    int            m_cnt;
    bit            m_hit;

    function automatic logic [LW-1:0] line_data(input logic [31:0] a);
        logic [LW-1:0] d;
        for (int w = 0; w < WORDS; w++) begin
            d[w*32 +: 32] = 32'h2000_0000 ^ (a << 11) ^ 32'(w + 3);
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_busy       = 1'b0;
        m_flush_pend = 1'b0;
        m_addr       = 32'h0;
        m_cnt        = 0;
    endtask

    task automatic model_check();
        int          i;
        int          w;
        logic [31:0] e_instr;
        i = int'(addr_i[9:5]);
        w = int'(addr_i[4:2]);
        m_hit = !m_busy && req_i && m_valid[i] && (m_tag[i] == addr_i[31:10]);
        e_instr = m_hit ? m_data[i][w*32 +: 32] : 32'h0;
        chk("instr", instr_o, e_instr);
        chk("stall", {31'b0, stall_o}, {31'b0, m_busy || (req_i && !m_hit)});
        chk("mem_req", {31'b0, mem_req_o}, {31'b0, m_busy});
        chk("mem_addr", mem_addr_o, m_addr);
        chk("miss_cnt", {16'b0, miss_cnt_o}, 32'(m_cnt));
    endtask

    task automatic model_step();
        int i;
        if (rst_i) begin
            model_reset();
        end else if (!m_busy) begin
            if (flush_i) begin
                for (int k = 0; k < LINES; k++) m_valid[k] = 1'b0;
            end
            if (req_i && !m_hit) begin
                m_busy = 1'b1;
                m_addr = addr_i & 32'hFFFF_FFE0;
                if (m_cnt < 65535) m_cnt++;
            end
        end else begin
            if (flush_i) m_flush_pend = 1'b1;
            if (mem_ack_i) begin
                i = int'(m_addr[9:5]);
                m_valid[i] = 1'b1;
                m_tag[i]   = m_addr[31:10];
                m_data[i]  = mem_data_i;
                if (m_flush_pend) begin
                    for (int k = 0; k < LINES; k++) m_valid[k] = 1'b0;
                end
                m_flush_pend = 1'b0;
                m_busy       = 1'b0;
            end
        end
    endtask

    // One clock: compare on the falling edge, advance the model, return just after the rising edge.
    task automatic cyc();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ack(input logic [31:0] line);
        mem_ack_i  = 1'b1;
        mem_data_i = line_data(line);
        cyc();
        mem_ack_i  = 1'b0;
    endtask

    initial begin
        rst_i      = 1'b1;
        req_i      = 1'b0;
        addr_i     = 32'h0;
        flush_i    = 1'b0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        model_reset();
        #12;
        chk("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
        chk("rst_stall", {31'b0, stall_o}, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_cnt", {16'b0, miss_cnt_o}, 32'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // 1: cold miss
        req_i  = 1'b1;
        addr_i = 32'h0000_0040;
        cyc();
        chk("t1_mem_req", {31'b0, mem_req_o}, 32'h1);
        chk("t1_mem_addr", mem_addr_o, 32'h0000_0040);
        chk("t1_cnt", {16'b0, miss_cnt_o}, 32'h1);

        // 2: ack after three wait cycles, then hit on word 2
        addr_i = 32'h0000_0048;
        repeat (3) cyc();
        do_ack(32'h0000_0040);
        #1;
        chk("t2_mem_req_drop", {31'b0, mem_req_o}, 32'h0);
        chk("t2_stall", {31'b0, stall_o}, 32'h0);
        chk("t2_instr", instr_o, 32'h2002_0005);
        cyc();
        cyc();
        chk("t2_cnt", {16'b0, miss_cnt_o}, 32'h1);

        // 3: conflict eviction on the same index
        addr_i = 32'h0000_0440;
        cyc();
        do_ack(32'h0000_0440);
        cyc();
        addr_i = 32'h0000_0040;
        cyc();
        do_ack(32'h0000_0040);
        cyc();
        chk("t3_cnt", {16'b0, miss_cnt_o}, 32'h3);

        // 4: redirect during refill does not change the refill address
        req_i   = 1'b0;
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        req_i   = 1'b1;
        addr_i  = 32'h0000_0040;
        cyc();
        addr_i  = 32'h0000_0080;
        cyc();
        chk("t4_mem_addr_hold", mem_addr_o, 32'h0000_0040);
        do_ack(32'h0000_0040);
        cyc();
        chk("t4_mem_addr_new", mem_addr_o, 32'h0000_0080);

        // 5: flush during refill leaves everything invalid
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        cyc();
        do_ack(32'h0000_0080);
        #1;
        chk("t5_refetch_miss", {31'b0, stall_o}, 32'h1);
        cyc();
        do_ack(32'h0000_0080);
        cyc();

        // 6: reset in the middle of a refill, late ack ignored
        addr_i = 32'h0000_0440;
        cyc();
        #1;
        rst_i = 1'b1;
        req_i = 1'b0;
        model_reset();
        #1;
        chk("t6_mem_req", {31'b0, mem_req_o}, 32'h0);
        chk("t6_cnt", {16'b0, miss_cnt_o}, 32'h0);
        cyc();
        rst_i = 1'b0;
        do_ack(32'h0000_0440);
        req_i  = 1'b1;
        addr_i = 32'h0000_0440;
        #1;
        chk("t6_no_valid", {31'b0, stall_o}, 32'h1);
        cyc();
        chk("t6_mem_addr", mem_addr_o, 32'h0000_0440);
        chk("t6_cnt_after", {16'b0, miss_cnt_o}, 32'h1);

        // Randomized traffic over a small address pool to get hits and conflicts
        for (int n = 0; n < 3000; n++) begin
            req_i   = ($urandom % 10) != 0;
            flush_i = ($urandom % 25) == 0;
            addr_i  = (($urandom % 4) << 10) | (($urandom % 4) << 5) |
                      (($urandom % 8) << 2) | ($urandom % 4);
            if (m_busy) begin
                mem_ack_i  = ($urandom % 3) == 0;
                mem_data_i = line_data(m_addr);
            end else begin
                mem_ack_i  = ($urandom % 10) == 0;
                mem_data_i = {8{$urandom}};
            end
            if (($urandom % 500) == 0) begin
                rst_i = 1'b1;
                model_reset();
            end
            cyc();
            rst_i = 1'b0;
        end
        mem_ack_i = 1'b0;
        req_i     = 1'b0;
        flush_i   = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
